hazard_ctrl_dual: RTL and testbench

Parametrised pipeline hazard and stall controller for the dual-issue five-stage (F/D/E/M/W) core. It is the successor to the single-slot combinational hazard unit, and adds the following:

- a registered load-use tracker of configurable depth covering every issue slot;
- intra-bundle dependency detection that splits a dual-issue bundle;
- a divider busy FSM with exception-driven cancel;
- a stall-cycle performance counter.

It sits beside the decode stage and drives the enable/flush controls of every pipeline register.

---
 rtl/hazard_ctrl_dual.sv | 128 ++++++++++++
 tb/tb_hazard_ctrl_dual.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_dual.sv
// Hazard and stall controller for the dual-issue F/D/E/M/W core: load-use
// tracking, intra-bundle split, divider busy FSM and stall-cycle counter.
module hazard_ctrl_dual #(
  parameter int ISSUE_W  = 2,
  parameter int LOAD_LAT = 2,
  parameter int REG_AW   = 5
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [ISSUE_W-1:0]        D_valid,
  input  logic [ISSUE_W*REG_AW-1:0] D_rs,
  input  logic [ISSUE_W*REG_AW-1:0] D_rt,
  input  logic [ISSUE_W-1:0]        D_memtoReg,
  input  logic [ISSUE_W*REG_AW-1:0] D_reg_waddr,
  input  logic [ISSUE_W-1:0]        D_reg_we,
  input  logic [ISSUE_W-1:0]        D_is_div,
  input  logic                      E_div_done,
  input  logic                      E_branch_taken,
  input  logic                      M_except,
  output logic                      F_ena,
  output logic                      D_ena,
  output logic                      E_ena,
  output logic                      M_ena,
  output logic                      W_ena,
  output logic                      F_flush,
  output logic                      D_flush,
  output logic                      E_flush,
  output logic                      M_flush,
  output logic                      W_flush,
  output logic                      D_slave_hold,
  output logic                      div_cancel,
  output logic [31:0]               stall_cnt
);

  typedef enum logic {DIV_IDLE, DIV_BUSY} div_state_t;
  div_state_t div_state;

  logic [ISSUE_W-1:0] trk_v    [LOAD_LAT];
  logic [REG_AW-1:0]  trk_addr [LOAD_LAT][ISSUE_W];

  logic               lwstall;
  logic               div_busy;
  logic [ISSUE_W-1:0] issue_mask;
  logic [ISSUE_W-1:0] cap_v;

  generate
    if (ISSUE_W == 2) begin : g_dual
      logic [REG_AW-1:0] waddr0, rs1, rt1;
      logic              raw_hit;
      assign waddr0  = D_reg_waddr[0 +: REG_AW];
      assign rs1     = D_rs[REG_AW +: REG_AW];
      assign rt1     = D_rt[REG_AW +: REG_AW];
      assign raw_hit = D_reg_we[0] && (waddr0 != '0) && ((waddr0 == rs1) || (waddr0 == rt1));
      assign D_slave_hold = D_valid[1] && (raw_hit || D_is_div[1] || (D_is_div[0] && D_valid[0]));
    end else begin : g_single
      assign D_slave_hold = 1'b0;
    end
  endgenerate

  // A held slave is not issuing, so it neither stalls nor enters the tracker
  always_comb begin
    issue_mask = D_valid;
    if (D_slave_hold) issue_mask[ISSUE_W-1] = 1'b0;
  end

  always_comb begin
    lwstall = 1'b0;
    for (int k = 0; k < LOAD_LAT; k++)
      for (int j = 0; j < ISSUE_W; j++)
        for (int i = 0; i < ISSUE_W; i++)
          if (trk_v[k][j] && (trk_addr[k][j] != '0) && issue_mask[i] &&
              ((trk_addr[k][j] == D_rs[i*REG_AW +: REG_AW]) ||
               (trk_addr[k][j] == D_rt[i*REG_AW +: REG_AW])))
            lwstall = 1'b1;
  end

  assign div_busy   = (div_state == DIV_BUSY) && !E_div_done;
  assign div_cancel = (div_state == DIV_BUSY) && M_except;

  assign F_ena   = !(lwstall || div_busy);
  assign D_ena   = F_ena;
  assign E_ena   = !div_busy;
  assign M_ena   = E_ena;
  assign W_ena   = !div_busy || M_except;
  assign F_flush = 1'b0;
  assign D_flush = M_except || E_branch_taken;
  assign E_flush = D_flush;
  assign M_flush = M_except;
  assign W_flush = 1'b0;

  assign cap_v = issue_mask & D_memtoReg & D_reg_we & {ISSUE_W{D_ena && !D_flush}};

  // Tracker valid bits; a flushed stage-0 load is killed rather than advanced
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int k = 0; k < LOAD_LAT; k++) trk_v[k] <= {ISSUE_W{1'b0}};
    end else begin
      if (E_flush)    trk_v[0] <= {ISSUE_W{1'b0}};
      else if (E_ena) trk_v[0] <= cap_v;
      for (int k = 1; k < LOAD_LAT; k++) begin
        if (M_flush)    trk_v[k] <= {ISSUE_W{1'b0}};
        else if (E_ena) trk_v[k] <= (k == 1 && E_flush) ? {ISSUE_W{1'b0}} : trk_v[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (E_ena) begin
      for (int j = 0; j < ISSUE_W; j++) trk_addr[0][j] <= D_reg_waddr[j*REG_AW +: REG_AW];
      for (int k = 1; k < LOAD_LAT; k++) trk_addr[k] <= trk_addr[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      div_state <= DIV_IDLE;
      stall_cnt <= '0;
    end else begin
      if (!D_ena) stall_cnt <= stall_cnt + 32'd1;
      case (div_state)
        DIV_IDLE: if (D_ena && D_valid[0] && D_is_div[0] && !D_flush) div_state <= DIV_BUSY;
        DIV_BUSY: if (M_except || E_div_done) div_state <= DIV_IDLE;
        default:  div_state <= DIV_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_ctrl_dual.sv
// Bench for hazard_ctrl_dual: directed scenarios followed by random bundles,
// all checked against an in-flight-load list and divider-busy flag model.
module tb_hazard_ctrl_dual;
  localparam int IW = 2;
  localparam int LL = 2;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic resetn;
  logic [IW-1:0]    d_valid, d_mem, d_we, d_div;
  logic [IW*AW-1:0] d_rs, d_rt, d_waddr;
  logic div_done, br, m_exc;
  logic f_ena, d_ena, e_ena, m_ena, w_ena;
  logic f_flush, d_flush, e_flush, m_flush, w_flush;
  logic slave_hold, div_cancel;
  logic [31:0] stall_cnt;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct { logic [4:0] addr; int age; } ld_t;
  ld_t loads[$];
  bit m_busy;
  logic [31:0] m_cnt;
  logic e_hold, e_lw, e_busy, e_dena, e_eena, e_wena, e_dflush, e_cancel;
  logic [11:0] e_ctrl;
  logic [11:0] ctrl;

  assign ctrl = {f_ena, d_ena, e_ena, m_ena, w_ena, f_flush, d_flush, e_flush,
                 m_flush, w_flush, slave_hold, div_cancel};

  hazard_ctrl_dual #(.ISSUE_W(IW), .LOAD_LAT(LL), .REG_AW(AW)) dut (
    .clk(clk), .resetn(resetn), .D_valid(d_valid), .D_rs(d_rs), .D_rt(d_rt),
    .D_memtoReg(d_mem), .D_reg_waddr(d_waddr), .D_reg_we(d_we), .D_is_div(d_div),
    .E_div_done(div_done), .E_branch_taken(br), .M_except(m_exc),
    .F_ena(f_ena), .D_ena(d_ena), .E_ena(e_ena), .M_ena(m_ena), .W_ena(w_ena),
    .F_flush(f_flush), .D_flush(d_flush), .E_flush(e_flush), .M_flush(m_flush),
    .W_flush(w_flush), .D_slave_hold(slave_hold), .div_cancel(div_cancel),
    .stall_cnt(stall_cnt));

  always #5 clk = ~clk;

  function automatic logic [4:0] fld(logic [IW*AW-1:0] v, int i);
    return v[i*AW +: AW];
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    d_valid = '0; d_mem = '0; d_we = '0; d_div = '0;
    d_rs = '0; d_rt = '0; d_waddr = '0;
    div_done = 1'b0; br = 1'b0; m_exc = 1'b0;
  endtask

  task automatic slot(int i, bit v, bit mem, bit we, bit dv, int wa, int rs, int rt);
    d_valid[i] = v; d_mem[i] = mem; d_we[i] = we; d_div[i] = dv;
    d_waddr[i*AW +: AW] = 5'(wa);
    d_rs[i*AW +: AW]    = 5'(rs);
    d_rt[i*AW +: AW]    = 5'(rt);
  endtask

  // Expected outputs from the pending-load list and divider flag
  task automatic compute();
    bit raw;
    logic [4:0] w0;
    w0  = fld(d_waddr, 0);
    raw = d_we[0] && (w0 != 0) && (w0 == fld(d_rs, 1) || w0 == fld(d_rt, 1));
    e_hold = d_valid[1] && (raw || d_div[1] || (d_div[0] && d_valid[0]));
    e_lw = 1'b0;
    foreach (loads[n])
      for (int i = 0; i < IW; i++)
        if (loads[n].addr != 0 && d_valid[i] && !(i == 1 && e_hold) &&
            (loads[n].addr == fld(d_rs, i) || loads[n].addr == fld(d_rt, i)))
          e_lw = 1'b1;
    e_busy   = m_busy && !div_done;
    e_dena   = !(e_lw || e_busy);
    e_eena   = !e_busy;
    e_wena   = !e_busy || m_exc;
    e_dflush = m_exc || br;
    e_cancel = m_busy && m_exc;
    e_ctrl   = {e_dena, e_dena, e_eena, e_eena, e_wena, 1'b0, e_dflush, e_dflush,
                m_exc, 1'b0, e_hold, e_cancel};
  endtask

  task automatic settle();
    #2;
    compute();
    chk("ctrl", 32'(ctrl), 32'(e_ctrl));
    chk("stall_cnt", stall_cnt, m_cnt);
  endtask

  task automatic clk_edge();
    ld_t keep[$];
    @(posedge clk);
    if (!resetn) begin
      loads.delete();
      m_busy = 1'b0;
      m_cnt  = '0;
    end else begin
      if (!e_dena) m_cnt = m_cnt + 32'd1;
      foreach (loads[n]) begin
        ld_t e;
        e = loads[n];
        if (e_dflush && e.age == 0) continue;
        if (m_exc && e.age >= 1) continue;
        if (e_eena) e.age++;
        if (e.age < LL) keep.push_back(e);
      end
      if (e_dena && !e_dflush)
        for (int i = 0; i < IW; i++)
          if (d_valid[i] && !(i == 1 && e_hold) && d_mem[i] && d_we[i])
            keep.push_back('{fld(d_waddr, i), 0});
      loads = keep;
      if (!m_busy) m_busy = e_dena && d_valid[0] && d_div[0] && !e_dflush;
      else if (m_exc || div_done) m_busy = 1'b0;
    end
    #1;
  endtask

  initial begin
    m_busy = 1'b0;
    m_cnt  = '0;
    idle();
    resetn = 1'b0;
    settle(); clk_edge();
    settle(); clk_edge();
    resetn = 1'b1;
    settle();
    chk("reset_ctrl", 32'(ctrl), 32'h0000_0F80);
    chk("reset_cnt", stall_cnt, 32'd0);

    // Load-use on slot 0
    slot(0, 1, 1, 1, 0, 5, 0, 0);
    settle(); clk_edge();
    idle(); slot(0, 1, 0, 1, 0, 6, 5, 0);
    settle(); chk("lu_stall0", 32'(d_ena), 32'd0); clk_edge();
    settle(); chk("lu_stall1", 32'(d_ena), 32'd0); clk_edge();
    settle(); chk("lu_release", 32'(d_ena), 32'd1); chk("lu_cnt", stall_cnt, 32'd2);
    clk_edge();

    // Intra-bundle RAW splits the bundle
    idle(); slot(0, 1, 0, 1, 0, 3, 1, 2); slot(1, 1, 0, 1, 0, 4, 3, 1);
    settle(); chk("split_hold", 32'(slave_hold), 32'd1); chk("split_dena", 32'(d_ena), 32'd1);
    clk_edge();

    // Load to $0 never stalls
    idle(); slot(0, 1, 1, 1, 0, 0, 0, 0);
    settle(); clk_edge();
    idle(); slot(0, 1, 0, 1, 0, 2, 0, 0); slot(1, 1, 0, 1, 0, 7, 0, 0);
    settle(); chk("zero_nostall", 32'(d_ena), 32'd1); clk_edge();

    // Divide completing 33 cycles after issue
    idle(); slot(0, 1, 0, 1, 1, 8, 1, 2);
    settle(); clk_edge();
    idle();
    for (int c = 0; c < 33; c++) begin
      settle();
      chk("div_e_ena", 32'(e_ena), 32'd0);
      chk("div_w_ena", 32'(w_ena), 32'd0);
      clk_edge();
    end
    div_done = 1'b1;
    settle(); chk("div_done_ena", 32'({f_ena, d_ena, e_ena, m_ena, w_ena}), 32'h1F); clk_edge();
    idle();
    settle(); chk("div_after", 32'({f_ena, d_ena, e_ena, m_ena, w_ena}), 32'h1F); clk_edge();

    // Exception cancels the divide on cycle 10 of BUSY
    slot(0, 1, 0, 1, 1, 8, 1, 2);
    settle(); clk_edge();
    idle();
    for (int c = 0; c < 9; c++) begin settle(); clk_edge(); end
    m_exc = 1'b1;
    settle();
    chk("cxl_pulse", 32'(div_cancel), 32'd1);
    chk("cxl_w_ena", 32'(w_ena), 32'd1);
    chk("cxl_m_flush", 32'(m_flush), 32'd1);
    clk_edge();
    idle();
    settle(); chk("cxl_e_ena", 32'(e_ena), 32'd1); chk("cxl_once", 32'(div_cancel), 32'd0);
    clk_edge();

    // Branch kills a load sitting in stage 0
    slot(0, 1, 1, 1, 0, 7, 0, 0);
    settle(); clk_edge();
    idle(); br = 1'b1;
    settle(); clk_edge();
    idle(); slot(0, 1, 0, 1, 0, 9, 7, 7);
    settle(); chk("br_kill", 32'(d_ena), 32'd1); clk_edge();

    // Reset while busy with a pending load
    idle(); slot(0, 1, 1, 1, 0, 9, 0, 0);
    settle(); clk_edge();
    idle(); slot(0, 1, 0, 1, 1, 10, 1, 1);
    settle(); clk_edge();
    idle(); resetn = 1'b0;
    settle(); clk_edge();
    resetn = 1'b1; slot(0, 1, 0, 1, 0, 11, 9, 0);
    settle();
    chk("rst_ena", 32'({f_ena, d_ena, e_ena, m_ena, w_ena}), 32'h1F);
    chk("rst_cnt", stall_cnt, 32'd0);
    chk("rst_cancel", 32'(div_cancel), 32'd0);
    clk_edge();

    // Random bundles over a small register space to provoke hazards
    for (int c = 0; c < 600; c++) begin
      idle();
      for (int i = 0; i < IW; i++)
        slot(i, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
             $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      div_done = $urandom_range(0, 7) == 0;
      br       = $urandom_range(0, 9) == 0;
      m_exc    = $urandom_range(0, 19) == 0;
      resetn   = $urandom_range(0, 49) != 0;
      settle();
      clk_edge();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
